alu_exec_pipe: RTL

//  Two-stage registered execute wrapper around the combinational ALU.
//  - Accepts {a, b, opcode, fnClass} from the decode/issue logic over a valid/ready handshake.
//  - Registers the operands and drives one ALU instance from them.
//  - Captures out/zerof/ovf/c_out into a result register and presents them to writeback over valid/ready.
//  - Keeps sticky overflow/carry status and a count of completed ops.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu.sv | 34 +++
 rtl/alu_exec_pipe.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU encodings and request/response records
package alu_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] FN_SHIFT = 2'b00;
  localparam logic [1:0] FN_PASS  = 2'b01;
  localparam logic [1:0] FN_ARITH = 2'b10;
  localparam logic [1:0] FN_LOGIC = 2'b11;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b11;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [1:0]      opcode;
    logic [1:0]      fnclass;
  } alu_req_t;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zerof;
    logic            ovf;
    logic            cout;
  } alu_rsp_t;
endpackage

// File: rtl/alu.sv
// alu: combinational ALU; ovf/c_out only meaningful for the arithmetic class
module alu
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   opcode,
  input  logic [1:0]   fnclass,
  output logic [N-1:0] out,
  output logic         zerof,
  output logic         ovf,
  output logic         c_out
);
  localparam int SW = $clog2(N);
  logic         sub;
  logic [N-1:0] bb;
  logic [N:0]   sum;
  logic [N-1:0] lg;
  logic [N-1:0] sh;
  // subtraction is a + ~b + 1, so c_out means "no borrow" (a >= b unsigned)
  always_comb begin
    sub   = opcode == OP_SUB;
    bb    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {{N{1'b0}}, sub};
    lg    = opcode == OP_AND ? a & b : opcode == OP_OR ? a | b : opcode == OP_XOR ? a ^ b : ~(a | b);
    sh    = opcode == OP_SHL ? a << b[SW-1:0] : opcode == OP_SHR ? a >> b[SW-1:0] : a;
    out   = fnclass == FN_ARITH ? sum[N-1:0] : fnclass == FN_LOGIC ? lg : fnclass == FN_SHIFT ? sh : a;
    zerof = out == '0;
    ovf   = fnclass == FN_ARITH && a[N-1] == bb[N-1] && sum[N-1] != a[N-1];
    c_out = fnclass == FN_ARITH && sum[N];
  end
endmodule

// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage valid/ready execute wrapper around alu with sticky flags and op counter
module alu_exec_pipe
  import alu_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [1:0]       in_opcode,
  input  logic [1:0]       in_fnclass,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_zerof,
  output logic             out_ovf,
  output logic             out_cout,
  output logic             sticky_ovf,
  output logic             sticky_cout,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);
  logic         s1_valid;
  logic         s2_valid;
  logic         s2_ready;
  logic         consume;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic [1:0]   s1_op;
  logic [1:0]   s1_fn;
  logic [N-1:0] alu_out;
  logic         alu_z;
  logic         alu_v;
  logic         alu_c;
  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign out_valid = s2_valid;
  assign consume   = s2_valid && out_ready;
  alu #(.N(N)) u_alu (
    .a      (s1_a),
    .b      (s1_b),
    .opcode (s1_op),
    .fnclass(s1_fn),
    .out    (alu_out),
    .zerof  (alu_z),
    .ovf    (alu_v),
    .c_out  (alu_c)
  );
  // consume uses the pre-flush s2 contents, so a result leaving during flush still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s1_a        <= '0;
      s1_b        <= '0;
      s1_op       <= '0;
      s1_fn       <= '0;
      out_result  <= '0;
      out_zerof   <= 1'b0;
      out_ovf     <= 1'b0;
      out_cout    <= 1'b0;
      sticky_ovf  <= 1'b0;
      sticky_cout <= 1'b0;
      op_count    <= '0;
    end else begin
      s1_valid <= flush ? 1'b0 : in_ready ? in_valid : s1_valid;
      s2_valid <= flush ? 1'b0 : s2_ready ? s1_valid : s2_valid;
      if (in_valid && in_ready) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= in_opcode;
        s1_fn <= in_fnclass;
      end
      if (s1_valid && s2_ready) begin
        out_result <= alu_out;
        out_zerof  <= alu_z;
        out_ovf    <= alu_v;
        out_cout   <= alu_c;
      end
      if (consume) op_count <= op_count + 1'b1;
      sticky_ovf  <= (consume && out_ovf) || (sticky_ovf && !clr_sticky);
      sticky_cout <= (consume && out_cout) || (sticky_cout && !clr_sticky);
    end
  end
endmodule
